// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter sharing one registered CDB among N_REQ one-entry result buffers
module cdb_arbiter #(
  parameter int TAG_W = 4,
  parameter int N_REQ = 3,
  localparam int PW = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*TAG_W-1:0] req_tag,
  input  logic [N_REQ*32-1:0]    req_wdata,
  output logic                   cdb_wr,
  output logic [TAG_W-1:0]       cdb_tag,
  output logic [31:0]            cdb_wdata,
  output logic [PW-1:0]          cdb_src,
  output logic                   err_zero_tag
);
  logic [N_REQ-1:0] r_vld, w_grant, w_acc, w_load, w_zero;
  logic [TAG_W-1:0] r_tag [N_REQ];
  logic [31:0]      r_dat [N_REQ];
  logic [PW-1:0]    r_rr, w_win;
  logic             w_any;
  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v >= N_REQ ? v - N_REQ : v);
  endfunction
  always_comb begin
    w_grant = '0;
    w_win = '0;
    w_any = 1'b0;
    for (int k = 0; k < N_REQ; k++)
      if (!w_any && r_vld[wrap(int'(r_rr) + k)]) begin
        w_any = 1'b1;
        w_win = wrap(int'(r_rr) + k);
        w_grant[w_win] = 1'b1;
      end
  end
  assign req_ready = ~r_vld | w_grant;
  assign w_acc = req_valid & req_ready;
  for (genvar i = 0; i < N_REQ; i++) begin : g_port
    assign w_zero[i] = w_acc[i] && req_tag[i*TAG_W +: TAG_W] == '0;
  end
  assign w_load = w_acc & ~w_zero;
  // a refill on the granted port wins over the clear, so the slot stays valid with the new entry
  always_ff @(posedge clk)
    if (rst) begin
      r_vld <= '0;
      r_rr <= '0;
      err_zero_tag <= 1'b0;
      cdb_wr <= 1'b0;
      cdb_tag <= '0;
      cdb_wdata <= '0;
      cdb_src <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (w_load[i]) begin
          r_vld[i] <= 1'b1;
          r_tag[i] <= req_tag[i*TAG_W +: TAG_W];
          r_dat[i] <= req_wdata[i*32 +: 32];
        end else if (w_grant[i]) r_vld[i] <= 1'b0;
      if (|w_zero) err_zero_tag <= 1'b1;
      cdb_wr <= w_any;
      if (w_any) begin
        cdb_tag <= r_tag[w_win];
        cdb_wdata <= r_dat[w_win];
        cdb_src <= w_win;
        r_rr <= wrap(int'(w_win) + 1);
      end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vector table plus a contention scoreboard for cdb_arbiter
module tb_cdb_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic [2:0]  req_valid = '0, req_ready;
  logic [11:0] req_tag = '0;
  logic [95:0] req_wdata = '0;
  logic        cdb_wr, err_zero_tag;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_wdata;
  logic [1:0]  cdb_src;
  int total = 0, bad = 0;
  cdb_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_wdata(req_wdata), .cdb_wr(cdb_wr), .cdb_tag(cdb_tag),
    .cdb_wdata(cdb_wdata), .cdb_src(cdb_src), .err_zero_tag(err_zero_tag)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic r; logic [2:0] v; logic [3:0] t0, t1, t2;
    logic [2:0] rdy; logic wr; logic [3:0] tag; logic [1:0] src; logic err;
  } vec_t;
  vec_t tbl[$];
  function automatic logic [31:0] d(input logic [1:0] i, input logic [3:0] t);
    return 32'h9E3779B9 * {26'd0, i, t};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic add(input logic r, input logic [2:0] v, input logic [3:0] t0, t1, t2,
                     input logic [2:0] rdy, input logic wr, input logic [3:0] tag,
                     input logic [1:0] src, input logic err);
    vec_t e;
    e.r = r; e.v = v; e.t0 = t0; e.t1 = t1; e.t2 = t2;
    e.rdy = rdy; e.wr = wr; e.tag = tag; e.src = src; e.err = err;
    tbl.push_back(e);
  endtask
  logic [35:0] q [3][$];
  logic [3:0]  cur_t [3];
  logic [31:0] cur_d [3];
  logic [35:0] ent;
  initial begin
    //  r  v      t0 t1 t2  rdy    wr tag src err
    add(0, 3'b010, 0, 5, 0, 3'b111, 0, 0, 0, 0);
    add(0, 3'b000, 0, 0, 0, 3'b111, 1, 5, 1, 0);
    add(0, 3'b000, 0, 0, 0, 3'b111, 0, 5, 1, 0);
    add(0, 3'b100, 0, 0, 7, 3'b111, 0, 5, 1, 0);
    add(0, 3'b000, 0, 0, 0, 3'b111, 1, 7, 2, 0);
    add(0, 3'b111, 1, 2, 3, 3'b111, 0, 7, 2, 0);
    add(0, 3'b000, 0, 0, 0, 3'b001, 1, 1, 0, 0);
    add(0, 3'b000, 0, 0, 0, 3'b011, 1, 2, 1, 0);
    add(0, 3'b000, 0, 0, 0, 3'b111, 1, 3, 2, 0);
    add(0, 3'b000, 0, 0, 0, 3'b111, 0, 3, 2, 0);
    add(0, 3'b101, 1, 0, 9, 3'b111, 0, 3, 2, 0);
    add(0, 3'b001, 2, 0, 0, 3'b011, 1, 1, 0, 0);
    add(0, 3'b001, 3, 0, 0, 3'b110, 1, 9, 2, 0);
    add(0, 3'b001, 3, 0, 0, 3'b111, 1, 2, 0, 0);
    add(0, 3'b001, 4, 0, 0, 3'b111, 1, 3, 0, 0);
    add(0, 3'b000, 0, 0, 0, 3'b111, 1, 4, 0, 0);
    add(0, 3'b000, 0, 0, 0, 3'b111, 0, 4, 0, 0);
    add(0, 3'b100, 0, 0, 4, 3'b111, 0, 4, 0, 0);
    add(0, 3'b100, 0, 0, 5, 3'b111, 1, 4, 2, 0);
    add(0, 3'b100, 0, 0, 6, 3'b111, 1, 5, 2, 0);
    add(0, 3'b000, 0, 0, 0, 3'b111, 1, 6, 2, 0);
    add(0, 3'b000, 0, 0, 0, 3'b111, 0, 6, 2, 0);
    add(0, 3'b001, 0, 0, 0, 3'b111, 0, 6, 2, 1);
    add(0, 3'b000, 0, 0, 0, 3'b111, 0, 6, 2, 1);
    add(0, 3'b010, 0, 8, 0, 3'b111, 0, 6, 2, 1);
    add(0, 3'b000, 0, 0, 0, 3'b111, 1, 8, 1, 1);
    add(0, 3'b011, 1, 2, 0, 3'b111, 0, 8, 1, 1);
    add(1, 3'b111, 5, 6, 7, 3'b101, 0, 0, 0, 0);
    add(0, 3'b000, 0, 0, 0, 3'b111, 0, 0, 0, 0);
    add(0, 3'b110, 0, 3, 4, 3'b111, 0, 0, 0, 0);
    add(0, 3'b000, 0, 0, 0, 3'b011, 1, 3, 1, 0);
    add(0, 3'b000, 0, 0, 0, 3'b111, 1, 4, 2, 0);
    add(0, 3'b000, 0, 0, 0, 3'b111, 0, 4, 2, 0);
    repeat (2) @(posedge clk);
    foreach (tbl[n]) begin
      @(negedge clk);
      rst = tbl[n].r;
      req_valid = tbl[n].v;
      req_tag = {tbl[n].t2, tbl[n].t1, tbl[n].t0};
      req_wdata = {d(2, tbl[n].t2), d(1, tbl[n].t1), d(0, tbl[n].t0)};
      chk($sformatf("ready[%0d]", n), 32'(req_ready), 32'(tbl[n].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("wr[%0d]", n), 32'(cdb_wr), 32'(tbl[n].wr));
      chk($sformatf("tag[%0d]", n), 32'(cdb_tag), 32'(tbl[n].tag));
      chk($sformatf("src[%0d]", n), 32'(cdb_src), 32'(tbl[n].src));
      chk($sformatf("data[%0d]", n), cdb_wdata, d(tbl[n].src, tbl[n].tag));
      chk($sformatf("err[%0d]", n), 32'(err_zero_tag), 32'(tbl[n].err));
    end
    // all three ports stream under full contention; every accepted result must appear once, in order
    for (int i = 0; i < 3; i++) begin
      cur_t[i] = 4'(i + 1);
      cur_d[i] = d(2'(i), cur_t[i]) ^ 32'h5A5A0000;
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        req_valid[i] = k < 15;
        req_tag[i*4 +: 4] = cur_t[i];
        req_wdata[i*32 +: 32] = cur_d[i];
        if (req_valid[i] && req_ready[i]) begin
          q[i].push_back({cur_t[i], cur_d[i]});
          cur_t[i] = cur_t[i] == 4'd15 ? 4'd1 : cur_t[i] + 4'd1;
          cur_d[i] = cur_d[i] + 32'h00010003;
        end
      end
      @(posedge clk);
      #1;
      if (cdb_wr) begin
        if (cdb_src > 2'd2 || q[cdb_src].size() == 0) chk("stream_extra", 32'(cdb_src), 32'hFFFF_FFFF);
        else begin
          ent = q[cdb_src].pop_front();
          chk($sformatf("stream_tag_p%0d", cdb_src), 32'(cdb_tag), 32'(ent[35:32]));
          chk($sformatf("stream_data_p%0d", cdb_src), cdb_wdata, ent[31:0]);
        end
      end
    end
    for (int i = 0; i < 3; i++) chk($sformatf("stream_left_p%0d", i), q[i].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
